// File: rtl/if_stage_pc_pipe.sv
// if_stage_pc_pipe: fetch-stage state of a 5-stage RV32 pipeline.
// Holds the PC register and the IF/ID pipeline register. The PC advances to
// pc_next unless stalled. The IF/ID register captures instruction, PC and PC+4.
// For IF/ID the priority is flush, then stall, then load.
// Optional feature macro: PERF_CNT_EN adds saturating stall/flush counters.
module if_stage_pc_pipe #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic [31:0]      instr_f,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic [31:0]      instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_plus4_d,
    output logic             valid_d
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] pc_f_q, pc_f_d;
    logic [31:0]      instr_d_q, instr_d_d;
    logic [WIDTH-1:0] pc_d_q, pc_d_d;
    logic [WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
    logic             valid_d_q, valid_d_d;

    // Sequential PC; wrap-around past the top of the address space is silent.
    assign pc_plus4_f = pc_f_q + PC_STEP;

    // Next-PC select: hold when the fetch stage is stalled.
    always_comb begin
        pc_f_d = pc_f_q;
        if (!stall_f) begin
            pc_f_d = pc_next;
        end
    end

    // IF/ID next-state: a flush wins over a stall, and a stall wins over a load.
    always_comb begin
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        if (flush_d) begin
            instr_d_d    = NOP_INSTR;
            pc_d_d       = '0;
            pc_plus4_d_d = '0;
            valid_d_d    = 1'b0;
        end else if (!stall_d) begin
            instr_d_d    = instr_f;
            pc_d_d       = pc_f_q;
            pc_plus4_d_d = pc_plus4_f;
            valid_d_d    = 1'b1;
        end
    end

    // PC and IF/ID registers; reset immediately loads a bubble and RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q       <= RESET_PC;
            instr_d_q    <= NOP_INSTR;
            pc_d_q       <= '0;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
        end else begin
            pc_f_q       <= pc_f_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    assign pc_f       = pc_f_q;
    assign instr_d    = instr_d_q;
    assign pc_d       = pc_d_q;
    assign pc_plus4_d = pc_plus4_d_q;
    assign valid_d    = valid_d_q;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counter increments. A flush takes precedence, so a flushed cycle does
    // not count as a stall. Both counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && !flush_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_d && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Performance counters not built in this configuration.
`endif

endmodule
